// File: rtl/mem_xbar.sv
// N-master x M-slave SRAM crossbar: address decode, per-slave round-robin arbitration, 1-cycle responses.
// Optional MEM_XBAR_ERR_RESP_EN: unmapped accesses report m_err_o=1 alongside their rvalid.
module mem_xbar #(
   parameter int N_MASTERS        = 2,
   parameter int N_SLAVES         = 2,
   parameter int ADDR_WIDTH       = 32,
   parameter int DATA_WIDTH       = 32,
   parameter int SLAVE_ADDR_WIDTH = 15,
   parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {32'h2000_0000, 32'h1000_0000}
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [N_MASTERS-1:0]                 m_req_i,
   output logic [N_MASTERS-1:0]                 m_gnt_o,
   output logic [N_MASTERS-1:0]                 m_rvalid_o,
   output logic [N_MASTERS-1:0]                 m_err_o,
   input  logic [N_MASTERS-1:0]                 m_we_i,
   input  logic [N_MASTERS*DATA_WIDTH/8-1:0]    m_be_i,
   input  logic [N_MASTERS*ADDR_WIDTH-1:0]      m_addr_i,
   input  logic [N_MASTERS*DATA_WIDTH-1:0]      m_wdata_i,
   output logic [N_MASTERS*DATA_WIDTH-1:0]      m_rdata_o,
   output logic [N_SLAVES-1:0]                  s_en_o,
   output logic [N_SLAVES-1:0]                  s_we_o,
   output logic [N_SLAVES*DATA_WIDTH/8-1:0]     s_be_o,
   output logic [N_SLAVES*SLAVE_ADDR_WIDTH-1:0] s_addr_o,
   output logic [N_SLAVES*DATA_WIDTH-1:0]       s_wdata_o,
   input  logic [N_SLAVES*DATA_WIDTH-1:0]       s_rdata_i
);

   localparam int BE_W = DATA_WIDTH / 8;
   localparam int MW   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int SW   = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   localparam int TW   = ADDR_WIDTH - SLAVE_ADDR_WIDTH;

   logic [ADDR_WIDTH-1:0] addr  [N_MASTERS];
   logic [BE_W-1:0]       be    [N_MASTERS];
   logic [DATA_WIDTH-1:0] wdata [N_MASTERS];
   logic [DATA_WIDTH-1:0] rdata [N_SLAVES];

   logic [N_MASTERS-1:0]  mapped;
   logic [SW-1:0]         slv [N_MASTERS];

   logic [N_SLAVES-1:0]   win_vld;
   logic [MW-1:0]         win  [N_SLAVES];
   logic [MW-1:0]         rr_q [N_SLAVES];
   logic [N_MASTERS-1:0]  gnt;

   logic [N_MASTERS-1:0]  rvalid_q;
   logic [N_MASTERS-1:0]  err_q;
   logic [SW-1:0]         sel_q [N_MASTERS];

   always_comb begin
      for (int k = 0; k < N_MASTERS; k++) begin
         addr[k]  = m_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
         be[k]    = m_be_i[k*BE_W +: BE_W];
         wdata[k] = m_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
      for (int i = 0; i < N_SLAVES; i++) begin
         rdata[i] = s_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Decode: scanning downwards lets the lowest matching slave win on overlap.
   always_comb begin
      for (int k = 0; k < N_MASTERS; k++) begin
         mapped[k] = 1'b0;
         slv[k]    = '0;
         for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (addr[k][ADDR_WIDTH-1:SLAVE_ADDR_WIDTH] ==
                SLAVE_BASE[i*ADDR_WIDTH+SLAVE_ADDR_WIDTH +: TW]) begin
               mapped[k] = 1'b1;
               slv[k]    = SW'(i);
            end
         end
      end
   end

   // Arbitration: first requesting master at or after rr_q (cyclic) wins each slave.
   always_comb begin
      int idx;
      idx = 0;
      for (int i = 0; i < N_SLAVES; i++) begin
         win_vld[i] = 1'b0;
         win[i]     = '0;
         for (int o = 0; o < N_MASTERS; o++) begin
            idx = int'(rr_q[i]) + o;
            if (idx >= N_MASTERS) idx = idx - N_MASTERS;
            if (!win_vld[i] && !rst && m_req_i[idx] && mapped[idx] && slv[idx] == SW'(i)) begin
               win_vld[i] = 1'b1;
               win[i]     = MW'(idx);
            end
         end
      end
   end

   // Unmapped requests bypass arbitration and are always accepted.
   always_comb begin
      gnt = '0;
      for (int k = 0; k < N_MASTERS; k++) begin
         if (!rst && m_req_i[k] && !mapped[k]) gnt[k] = 1'b1;
      end
      for (int i = 0; i < N_SLAVES; i++) begin
         if (win_vld[i]) gnt[win[i]] = 1'b1;
      end
   end

   always_comb begin
      s_en_o    = '0;
      s_we_o    = '0;
      s_be_o    = '0;
      s_addr_o  = '0;
      s_wdata_o = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (win_vld[i]) begin
            s_en_o[i]                                            = 1'b1;
            s_we_o[i]                                            = m_we_i[win[i]];
            s_be_o[i*BE_W +: BE_W]                               = be[win[i]];
            s_addr_o[i*SLAVE_ADDR_WIDTH +: SLAVE_ADDR_WIDTH]     = addr[win[i]][SLAVE_ADDR_WIDTH-1:0];
            s_wdata_o[i*DATA_WIDTH +: DATA_WIDTH]                = wdata[win[i]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_SLAVES; i++) rr_q[i] <= '0;
      end else begin
         for (int i = 0; i < N_SLAVES; i++) begin
            if (win_vld[i]) rr_q[i] <= (win[i] == MW'(N_MASTERS - 1)) ? '0 : win[i] + 1'b1;
         end
      end
   end

   // Response stage: grant in cycle t presents rvalid/rdata in cycle t+1.
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q <= '0;
         err_q    <= '0;
         for (int k = 0; k < N_MASTERS; k++) sel_q[k] <= '0;
      end else begin
         rvalid_q <= gnt;
         for (int k = 0; k < N_MASTERS; k++) begin
            if (gnt[k]) begin
               err_q[k] <= !mapped[k];
               sel_q[k] <= slv[k];
            end
         end
      end
   end

   assign m_gnt_o    = gnt;
   assign m_rvalid_o = rvalid_q;

`ifdef MEM_XBAR_ERR_RESP_EN
   assign m_err_o = rvalid_q & err_q;
`else
   assign m_err_o = '0;
`endif

   // err_q doubles as the "unmapped" marker, forcing rdata to zero either way.
   always_comb begin
      m_rdata_o = '0;
      for (int k = 0; k < N_MASTERS; k++) begin
         if (rvalid_q[k] && !err_q[k]) m_rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rdata[sel_q[k]];
      end
   end

endmodule
